// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Groups the keypad pins and the key-event outputs of keypad_scanner.
//   Pins:
//     row_n       raw active-low row sense lines (asynchronous)
//     col_n       active-low column drive lines, one driven at a time
//   Events:
//     key_code    index (row*N_COLS + col) of the last accepted single key
//     key_valid   one-cycle pulse when a new single key is accepted
//     key_release one-cycle pulse when the matrix returns to all-released
//     key_down    level, exactly one debounced key pressed
//     multi_key   level, two or more debounced keys pressed
//   Modports:
//     master      scanner side (drives columns and events)
//     slave       keypad / consumer side (drives rows, observes the rest)
interface keypad_scanner_if #(
    parameter int N_ROWS = 4,
    parameter int N_COLS = 4,
    parameter int KEY_W  = (N_ROWS * N_COLS > 1) ? $clog2(N_ROWS * N_COLS) : 1
);
    logic [N_ROWS-1:0] row_n;
    logic [N_COLS-1:0] col_n;
    logic [KEY_W-1:0]  key_code;
    logic              key_valid;
    logic              key_release;
    logic              key_down;
    logic              multi_key;

    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_valid,
        output key_release,
        output key_down,
        output multi_key
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_release,
        input  key_down,
        input  multi_key
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Matrix keypad scanner. Drives one active-low column at a time for
//   SCAN_CYCLES clocks, samples the synchronised rows at the end of each
//   column dwell into a full-matrix bitmap, debounces whole frames and
//   reports single-key press/release events plus a multi-key level.
//   Ports:
//     clk  system clock, all logic on the rising edge
//     rst  synchronous active-high reset
//     kp   keypad_scanner_if.master (row_n in; col_n and key events out)
module keypad_scanner #(
    parameter int N_ROWS         = 4,
    parameter int N_COLS         = 4,
    parameter int SCAN_CYCLES    = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int KEY_W          = (N_ROWS * N_COLS > 1) ? $clog2(N_ROWS * N_COLS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int NK = N_ROWS * N_COLS;
    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

    localparam logic [DW-1:0]     DWELL_LAST  = DW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0]     COL_LAST    = CW'(N_COLS - 1);
    localparam logic [SW-1:0]     STABLE_MAX  = SW'(DEBOUNCE_SCANS - 1);
    localparam logic [N_COLS-1:0] COL_N_RESET = ~(N_COLS'(1));

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } key_class_t;

    // Number of pressed keys in a bitmap, reduced to none / one / several.
    function automatic key_class_t key_class(input logic [NK-1:0] bits);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < NK; i++) begin
            n += {31'd0, bits[i]};
        end
        if (n == 32'd0) begin
            return CLS_NONE;
        end else if (n == 32'd1) begin
            return CLS_SINGLE;
        end else begin
            return CLS_MULTI;
        end
    endfunction

    // Index of the lowest set bit; only meaningful for single-key bitmaps.
    function automatic logic [KEY_W-1:0] key_index(input logic [NK-1:0] bits);
        logic [KEY_W-1:0] idx;
        idx = {KEY_W{1'b0}};
        for (int i = NK - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = KEY_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [N_ROWS-1:0] sync1_r;
    logic [N_ROWS-1:0] sync2_r;
    logic [N_ROWS-1:0] row_s;
    logic [DW-1:0]     dwell_r;
    logic [CW-1:0]     col_r;
    logic [N_COLS-1:0] col_n_r;
    logic              dwell_wrap_s;
    logic              col_last_s;
    logic [CW-1:0]     col_next_s;
    logic [N_COLS-1:0] col_n_next_s;
    logic [NK-1:0]     frame_r;
    logic [NK-1:0]     frame_sampled_s;
    logic              frame_done_r;
    logic [NK-1:0]     prev_frame_r;
    logic [SW-1:0]     stable_r;
    logic [SW-1:0]     stable_next_s;
    logic [NK-1:0]     deb_r;
    logic [NK-1:0]     deb_seen_r;
    key_class_t        new_cls_s;
    key_class_t        old_cls_s;
    logic              valid_next_s;
    logic              release_next_s;
    logic [KEY_W-1:0]  code_next_s;
    logic [KEY_W-1:0]  key_code_r;
    logic              key_valid_r;
    logic              key_release_r;
    logic              key_down_r;
    logic              multi_key_r;

    // Two-flop synchroniser for the asynchronous row pins (idle = released).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {N_ROWS{1'b1}};
            sync2_r <= {N_ROWS{1'b1}};
        end else begin
            sync1_r <= kp.row_n;
            sync2_r <= sync1_r;
        end
    end

    assign row_s        = ~sync2_r;
    assign dwell_wrap_s = (dwell_r == DWELL_LAST);
    assign col_last_s   = (col_r == COL_LAST);

    // Next column index and its one-cold drive pattern.
    always_comb begin
        col_next_s   = col_last_s ? {CW{1'b0}} : (col_r + CW'(1));
        col_n_next_s = {N_COLS{1'b1}};
        for (int c = 0; c < N_COLS; c++) begin
            if (CW'(c) == col_next_s) begin
                col_n_next_s[c] = 1'b0;
            end else begin
                col_n_next_s[c] = 1'b1;
            end
        end
    end

    // Dwell/column counters; col_n moves on the same edge as col.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_r <= {DW{1'b0}};
            col_r   <= {CW{1'b0}};
            col_n_r <= COL_N_RESET;
        end else if (dwell_wrap_s) begin
            dwell_r <= {DW{1'b0}};
            col_r   <= col_next_s;
            col_n_r <= col_n_next_s;
        end else begin
            dwell_r <= dwell_r + DW'(1);
            col_r   <= col_r;
            col_n_r <= col_n_r;
        end
    end

    // Current rows merged into the active column of the frame bitmap.
    always_comb begin
        frame_sampled_s = frame_r;
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) begin
                if (CW'(c) == col_r) begin
                    frame_sampled_s[r * N_COLS + c] = row_s[r];
                end else begin
                    frame_sampled_s[r * N_COLS + c] = frame_r[r * N_COLS + c];
                end
            end
        end
    end

    // Frame capture at the end of each column dwell; flag the frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_r      <= {NK{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= dwell_wrap_s & col_last_s;
            if (dwell_wrap_s) begin
                frame_r <= frame_sampled_s;
            end else begin
                frame_r <= frame_r;
            end
        end
    end

    // Saturating count of consecutive identical frames.
    always_comb begin
        if (frame_r == prev_frame_r) begin
            if (stable_r == STABLE_MAX) begin
                stable_next_s = stable_r;
            end else begin
                stable_next_s = stable_r + SW'(1);
            end
        end else begin
            stable_next_s = {SW{1'b0}};
        end
    end

    // Debounce evaluation, one cycle after the last column sample of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_frame_r <= {NK{1'b0}};
            stable_r     <= {SW{1'b0}};
            deb_r        <= {NK{1'b0}};
        end else if (frame_done_r) begin
            prev_frame_r <= frame_r;
            stable_r     <= stable_next_s;
            if (stable_next_s == STABLE_MAX) begin
                deb_r <= frame_r;
            end else begin
                deb_r <= deb_r;
            end
        end else begin
            prev_frame_r <= prev_frame_r;
            stable_r     <= stable_r;
            deb_r        <= deb_r;
        end
    end

    // Event classification of the debounced matrix against its previous value.
    // A single key reached from a multi-key state is not reported, so a
    // roll-over never produces a spurious press.
    always_comb begin
        new_cls_s      = key_class(deb_r);
        old_cls_s      = key_class(deb_seen_r);
        valid_next_s   = 1'b0;
        release_next_s = 1'b0;
        code_next_s    = key_code_r;
        case (new_cls_s)
            CLS_SINGLE: begin
                if ((old_cls_s == CLS_NONE) ||
                    ((old_cls_s == CLS_SINGLE) && (deb_r != deb_seen_r))) begin
                    valid_next_s = 1'b1;
                    code_next_s  = key_index(deb_r);
                end else begin
                    valid_next_s = 1'b0;
                end
            end
            CLS_NONE: begin
                if (old_cls_s != CLS_NONE) begin
                    release_next_s = 1'b1;
                end else begin
                    release_next_s = 1'b0;
                end
            end
            CLS_MULTI: begin
                valid_next_s = 1'b0;
            end
            default: begin
                valid_next_s   = 1'b0;
                release_next_s = 1'b0;
            end
        endcase
    end

    // Registered event outputs and levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_seen_r    <= {NK{1'b0}};
            key_code_r    <= {KEY_W{1'b0}};
            key_valid_r   <= 1'b0;
            key_release_r <= 1'b0;
            key_down_r    <= 1'b0;
            multi_key_r   <= 1'b0;
        end else begin
            deb_seen_r    <= deb_r;
            key_code_r    <= code_next_s;
            key_valid_r   <= valid_next_s;
            key_release_r <= release_next_s;
            key_down_r    <= (new_cls_s == CLS_SINGLE);
            multi_key_r   <= (new_cls_s == CLS_MULTI);
        end
    end

    assign kp.col_n       = col_n_r;
    assign kp.key_code    = key_code_r;
    assign kp.key_valid   = key_valid_r;
    assign kp.key_release = key_release_r;
    assign kp.key_down    = key_down_r;
    assign kp.multi_key   = multi_key_r;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Self-checking bench for keypad_scanner (4x4, SCAN_CYCLES=4,
//   DEBOUNCE_SCANS=2). A keypad model pulls a row low while a held key's
//   column is driven. Expected outputs come from a frame-level model:
//   a frame is accepted when it equals the previous DEBOUNCE_SCANS-1
//   frames (released before reset), and events appear two cycles after
//   the frame end.
module tb_keypad_scanner;
    localparam int N_ROWS         = 4;
    localparam int N_COLS         = 4;
    localparam int SCAN_CYCLES    = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int FRAME_LEN      = N_COLS * SCAN_CYCLES;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] held = 16'h0000;
    logic [3:0]  row_n_s;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] hist[$];
    logic [15:0] exp_deb;
    logic        pend;
    logic [15:0] pend_deb;
    logic        exp_valid;
    logic        exp_release;
    logic        exp_down;
    logic        exp_multi;
    logic [3:0]  exp_code;

    keypad_scanner_if #(.N_ROWS(N_ROWS), .N_COLS(N_COLS)) kif ();

    keypad_scanner #(
        .N_ROWS(N_ROWS),
        .N_COLS(N_COLS),
        .SCAN_CYCLES(SCAN_CYCLES),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp(kif)
    );

    always #10 clk = ~clk;

    // Keypad matrix: a held key shorts its row to its driven (low) column.
    always_comb begin
        row_n_s = 4'b1111;
        for (int r = 0; r < N_ROWS; r++) begin
            for (int c = 0; c < N_COLS; c++) begin
                if (held[r * N_COLS + c] && !kif.col_n[c]) begin
                    row_n_s[r] = 1'b0;
                end
            end
        end
    end
    assign kif.row_n = row_n_s;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h time=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_deb     = 16'h0000;
        pend        = 1'b0;
        pend_deb    = 16'h0000;
        exp_valid   = 1'b0;
        exp_release = 1'b0;
        exp_down    = 1'b0;
        exp_multi   = 1'b0;
        exp_code    = 4'd0;
    endtask

    // True when the newest frame equals the DEBOUNCE_SCANS-1 before it.
    function automatic bit window_stable();
        int          last;
        logic [15:0] f;
        last = hist.size() - 1;
        for (int j = 1; j < DEBOUNCE_SCANS; j++) begin
            f = (last - j >= 0) ? hist[last - j] : 16'h0000;
            if (f != hist[last]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic apply_event(input logic [15:0] new_deb);
        int oc;
        int nc;
        oc = $countones(exp_deb);
        nc = $countones(new_deb);
        exp_valid   = 1'b0;
        exp_release = 1'b0;
        if (nc == 1 && (oc == 0 || (oc == 1 && new_deb != exp_deb))) begin
            exp_valid = 1'b1;
            for (int k = 0; k < 16; k++) begin
                if (new_deb[k]) exp_code = 4'(k);
            end
        end
        if (nc == 0 && oc != 0) exp_release = 1'b1;
        exp_down  = (nc == 1);
        exp_multi = (nc >= 2);
        exp_deb   = new_deb;
    endtask

    task automatic check_outputs(input logic [3:0] ecol);
        check_eq("col_n", 32'(kif.col_n), 32'(ecol));
        check_eq("key_valid", 32'(kif.key_valid), 32'(exp_valid));
        check_eq("key_release", 32'(kif.key_release), 32'(exp_release));
        check_eq("key_down", 32'(kif.key_down), 32'(exp_down));
        check_eq("multi_key", 32'(kif.multi_key), 32'(exp_multi));
        check_eq("key_code", 32'(kif.key_code), 32'(exp_code));
    endtask

    // Called #1 after an edge; leaves the bench #1 after the first fresh cycle edge.
    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs(4'b1110);
        rst = 1'b0;
    endtask

    // Hold `keys` for n cycles starting at a frame boundary, checking every cycle.
    task automatic run_intervals(input logic [15:0] keys, input int n);
        logic [3:0] ecol;
        held = keys;
        for (int i = 0; i < n; i++) begin
            if (i == 2 && pend) begin
                apply_event(pend_deb);
                pend = 1'b0;
            end else begin
                exp_valid   = 1'b0;
                exp_release = 1'b0;
            end
            ecol = ~(4'b0001 << (i / SCAN_CYCLES));
            @(negedge clk);
            check_outputs(ecol);
            @(posedge clk);
            #1;
        end
        if (n == FRAME_LEN) begin
            hist.push_back(keys);
            if (window_stable()) begin
                pend     = 1'b1;
                pend_deb = keys;
            end else begin
                pend = 1'b0;
            end
        end
    endtask

    task automatic run_frames(input logic [15:0] keys, input int nf);
        for (int f = 0; f < nf; f++) run_intervals(keys, FRAME_LEN);
    endtask

    initial begin
        logic [15:0] keys;
        int          hold;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // idle rotation across two frames
        run_frames(16'h0000, 2);
        // clean press of key (1,2) = code 6
        run_frames(16'h0040, 3);
        // one-frame bounce of (3,0) while (1,2) stays down
        run_frames(16'h1040, 1);
        run_frames(16'h0040, 2);
        // release
        run_frames(16'h0000, 3);
        // multi-key (0,0)+(2,3), drop (2,3), release all
        run_frames(16'h0801, 3);
        run_frames(16'h0001, 3);
        run_frames(16'h0000, 3);
        // mid-frame reset during column 2 with (1,2) held
        run_frames(16'h0040, 3);
        run_intervals(16'h0040, 10);
        apply_reset();
        run_frames(16'h0040, 3);
        run_frames(16'h0000, 3);

        // randomized segments
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(3, 0))
                0: keys = 16'h0000;
                1: keys = 16'h0001 << $urandom_range(15, 0);
                2: keys = (16'h0001 << $urandom_range(15, 0)) | (16'h0001 << $urandom_range(15, 0));
                default: keys = exp_deb ^ (16'h0001 << $urandom_range(15, 0));
            endcase
            hold = int'($urandom_range(3, 1));
            run_frames(keys, hold);
            if ($urandom_range(9, 0) == 0) begin
                run_intervals(keys, int'($urandom_range(15, 3)));
                apply_reset();
            end
        end
        run_frames(16'h0000, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
